// File: rtl/prog_mem_arbiter.sv
// prog_mem_arbiter: two requesters share one combinational program-memory read
// port. Round-robin grant, byte-to-word address conversion, misalignment and
// range flags, and a two-stage registered pipeline with fixed 2-cycle latency.
module prog_mem_arbiter #(
    parameter int unsigned MEM_WORDS = 256,
    parameter bit          LAT_FLAG  = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [31:0] req0_addr,
    output logic        req0_ready,
    output logic        rsp0_valid,
    output logic [31:0] rsp0_data,
    output logic        rsp0_err,
    input  logic        req1_valid,
    input  logic [31:0] req1_addr,
    output logic        req1_ready,
    output logic        rsp1_valid,
    output logic [31:0] rsp1_data,
    output logic        rsp1_err,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_data
);

    logic        last_grant;
    logic        accept;
    logic        acc_id;
    logic [31:0] acc_addr;

    logic        s1_valid;
    logic        s1_id;
    logic [29:0] s1_word;
    logic        s1_mis;
    logic        s1_oor;

    logic [31:0] s1_rdata;
    logic        s1_err;

    // Round-robin grant: contention goes to the port not granted last time
    always_comb begin
        req0_ready = req0_valid && (!req1_valid || last_grant);
        req1_ready = req1_valid && (!req0_valid || !last_grant);
        accept     = req0_ready || req1_ready;
        acc_id     = req1_ready;
        acc_addr   = req1_ready ? req1_addr : req0_addr;
    end

    // Remember which port was granted most recently
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= acc_id;
        end
    end

    // Stage 1: capture the accepted request and classify its address;
    // only the word index is kept since the byte offset is folded into s1_mis
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_id    <= 1'b0;
            s1_word  <= '0;
            s1_mis   <= 1'b0;
            s1_oor   <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_id   <= acc_id;
                s1_word <= acc_addr[31:2];
                s1_mis  <= (acc_addr[1:0] != 2'b00);
                s1_oor  <= ({2'b00, acc_addr[31:2]} >= 32'(MEM_WORDS));
            end
        end
    end

    assign mem_addr = {2'b00, s1_word};

    // Response word and error for the access currently in stage 1
    always_comb begin
        s1_rdata = (s1_mis || s1_oor) ? '0 : mem_data;
        s1_err   = s1_mis || (LAT_FLAG && s1_oor);
    end

    // Stage 2: one-cycle response pulse to the owning port; data/err hold otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp0_valid <= 1'b0;
            rsp0_data  <= '0;
            rsp0_err   <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp1_data  <= '0;
            rsp1_err   <= 1'b0;
        end else begin
            rsp0_valid <= s1_valid && !s1_id;
            rsp1_valid <= s1_valid && s1_id;
            if (s1_valid && !s1_id) begin
                rsp0_data <= s1_rdata;
                rsp0_err  <= s1_err;
            end
            if (s1_valid && s1_id) begin
                rsp1_data <= s1_rdata;
                rsp1_err  <= s1_err;
            end
        end
    end

endmodule

// File: tb/tb_prog_mem_arbiter.sv
// Bench for prog_mem_arbiter: two instances (LAT_FLAG 0 and 1, MEM_WORDS 16)
// driven with identical requests; a reference model predicts grants and
// responses into a scoreboard that a separate monitor drains.
module tb_prog_mem_arbiter;

    localparam int unsigned WORDS = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0;
    logic [31:0] req0_addr  = '0;
    logic        req1_valid = 1'b0;
    logic [31:0] req1_addr  = '0;

    logic        r0_a, r1_a, v0_a, v1_a, e0_a, e1_a;
    logic [31:0] d0_a, d1_a, ma_a, md_a;
    logic        r0_b, r1_b, v0_b, v1_b, e0_b, e1_b;
    logic [31:0] d0_b, d1_b, ma_b, md_b;

    logic [31:0] mem [WORDS];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int          port;
        logic [31:0] data;
        logic        err_a;
        logic        err_b;
        int          due;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] q0[$];
    logic [31:0] q1[$];

    prog_mem_arbiter #(.MEM_WORDS(WORDS), .LAT_FLAG(1'b0)) u_dut_a (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(r0_a),
        .rsp0_valid(v0_a), .rsp0_data(d0_a), .rsp0_err(e0_a),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(r1_a),
        .rsp1_valid(v1_a), .rsp1_data(d1_a), .rsp1_err(e1_a),
        .mem_addr(ma_a), .mem_data(md_a)
    );

    prog_mem_arbiter #(.MEM_WORDS(WORDS), .LAT_FLAG(1'b1)) u_dut_b (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(r0_b),
        .rsp0_valid(v0_b), .rsp0_data(d0_b), .rsp0_err(e0_b),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(r1_b),
        .rsp1_valid(v1_b), .rsp1_data(d1_b), .rsp1_err(e1_b),
        .mem_addr(ma_b), .mem_data(md_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model; out-of-range indices return a non-zero pattern so a missing
    // zeroing of out-of-range data is visible
    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (a < WORDS) return mem[a[3:0]];
        return {a[15:0], 16'hBEEF};
    endfunction

    assign md_a = mem_rd(ma_a);
    assign md_b = mem_rd(ma_b);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    // Reference model: grant prediction, memory-address tracking, scoreboard push
    int          last_srv  = 1;
    logic [31:0] prev_addr = '0;
    always @(negedge clk) begin
        int          win;
        logic [31:0] a;
        logic [31:0] idx;
        logic        mis, oor;
        exp_t        e;
        if (rst) begin
            sbq.delete();
            last_srv  = 1;
            prev_addr = '0;
            chk("reset_rsp_a", {30'd0, v1_a, v0_a}, 32'd0);
            chk("reset_rsp_b", {30'd0, v1_b, v0_b}, 32'd0);
            chk("reset_err", {28'd0, e1_a, e0_a, e1_b, e0_b}, 32'd0);
            chk("reset_data_a", d0_a | d1_a, 32'd0);
            chk("reset_data_b", d0_b | d1_b, 32'd0);
            chk("reset_mem_addr", ma_a | ma_b, 32'd0);
        end else begin
            // memory sees the word index of the most recent accepted request
            chk("mem_addr_a", ma_a, prev_addr >> 2);
            chk("mem_addr_b", ma_b, prev_addr >> 2);
            if (req0_valid && req1_valid) win = 1 - last_srv;
            else if (req0_valid)          win = 0;
            else if (req1_valid)          win = 1;
            else                          win = -1;
            chk("ready_a", {30'd0, r1_a, r0_a}, (win == 0) ? 32'd1 : (win == 1) ? 32'd2 : 32'd0);
            chk("ready_b", {30'd0, r1_b, r0_b}, (win == 0) ? 32'd1 : (win == 1) ? 32'd2 : 32'd0);
            if (win >= 0) begin
                a   = (win == 0) ? req0_addr : req1_addr;
                idx = a / 4;
                mis = (a % 4) != 0;
                oor = idx >= WORDS;
                e.port  = win;
                e.data  = (mis || oor) ? 32'd0 : mem[idx[3:0]];
                e.err_a = mis;
                e.err_b = mis || oor;
                e.due   = cyc + 2;
                sbq.push_back(e);
                last_srv  = win;
                prev_addr = a;
            end
        end
    end

    // Monitor: every response pulse must match the oldest expected entry on time
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (sbq.size() != 0 && sbq[0].due == cyc) begin
                e = sbq.pop_front();
                chk("rsp_valid_a", {30'd0, v1_a, v0_a}, (e.port == 1) ? 32'd2 : 32'd1);
                chk("rsp_valid_b", {30'd0, v1_b, v0_b}, (e.port == 1) ? 32'd2 : 32'd1);
                chk("rsp_data_a", (e.port == 1) ? d1_a : d0_a, e.data);
                chk("rsp_data_b", (e.port == 1) ? d1_b : d0_b, e.data);
                chk("rsp_err_a", {31'd0, (e.port == 1) ? e1_a : e0_a}, {31'd0, e.err_a});
                chk("rsp_err_b", {31'd0, (e.port == 1) ? e1_b : e0_b}, {31'd0, e.err_b});
            end else begin
                chk("rsp_idle_a", {30'd0, v1_a, v0_a}, 32'd0);
                chk("rsp_idle_b", {30'd0, v1_b, v0_b}, 32'd0);
            end
        end
    end

    // One cycle of request driving; a port's head address is held until accepted
    task automatic step();
        logic g0, g1;
        req0_valid = (q0.size() != 0);
        req0_addr  = (q0.size() != 0) ? q0[0] : '0;
        req1_valid = (q1.size() != 0);
        req1_addr  = (q1.size() != 0) ? q1[0] : '0;
        @(negedge clk);
        g0 = r0_a;
        g1 = r1_a;
        @(posedge clk);
        #1;
        if (g0 && q0.size() != 0) q0.delete(0);
        if (g1 && q1.size() != 0) q1.delete(0);
    endtask

    // Drain request queues within a cycle budget, then let responses retire
    task automatic run();
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 100) begin
            step();
            n++;
        end
        chk("drain_budget", q0.size() + q1.size(), 32'd0);
        q0.delete();
        q1.delete();
        repeat (4) step();
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 7))
            0:       return ($urandom_range(0, 15) << 2) | $urandom_range(1, 3);
            1:       return $urandom | 32'h40;
            2:       return 32'h3C;
            3:       return 32'h40;
            default: return $urandom_range(0, 15) << 2;
        endcase
    endfunction

    initial begin
        for (int i = 0; i < int'(WORDS); i++) mem[i] = $urandom;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // single fetch
        q0 = '{32'h8};
        run();

        // continuous contention
        for (int i = 0; i < 8; i++) begin
            q0.push_back(32'(i * 4));
            q1.push_back(32'h20 + 32'(i * 4));
        end
        q1.push_back(32'h40);
        run();

        // misaligned and out-of-range
        q1 = '{32'h6};
        q0 = '{32'h40};
        run();

        // back-to-back port 0
        q0 = '{32'h0, 32'h4, 32'h8, 32'hC};
        run();

        // loser hold: port 1 alone first, then both
        q1 = '{32'h10, 32'h14};
        step();
        q0 = '{32'h0};
        run();

        // reset while an access is in flight
        q0 = '{32'h4};
        step();
        req0_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        q0 = '{32'h8};
        q1 = '{32'h28};
        run();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            if (q0.size() == 0 && $urandom_range(0, 2) != 0) q0.push_back(rand_addr());
            if (q1.size() == 0 && $urandom_range(0, 2) != 0) q1.push_back(rand_addr());
            step();
        end
        run();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
